// File: rtl/fetch_stage_q.sv
// Instruction-fetch stage: PC generation, decoupled IMEM requests and an in-order prefetch buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the fetch_misalign trap output.
module fetch_stage_q #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_misalign
`endif
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

   logic [XLEN-1:0] fetchPc;
   logic [PTRW-1:0] allocPtr;
   logic [PTRW-1:0] fillPtr;
   logic [PTRW-1:0] headPtr;
   logic [CNTW-1:0] count;
   logic [CNTW-1:0] dropCnt;
   logic [CNTW-1:0] unfilledCnt;

   logic [XLEN-1:0] pcMem     [DEPTH];
   logic [31:0]     instrMem  [DEPTH];
   logic            filledMem [DEPTH];

   logic [XLEN-1:0] redirTarget;
   logic            trapHold;
   logic            reqFire;
   logic            rspFill;
   logic            rspDrop;
   logic            pop;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalignReg;

   assign redirTarget    = redirect_pc;
   assign trapHold       = misalignReg;
   assign fetch_misalign = misalignReg;

   always_ff @(posedge clk) begin
      if (rst) begin
         misalignReg <= 1'b0;
      end else if (redirect_valid) begin
         misalignReg <= (redirect_pc[1:0] != 2'b00);
      end
   end
`else
   assign redirTarget = redirect_pc & ~XLEN'(3);
   assign trapHold    = 1'b0;
`endif

   assign imem_req_valid = !rst && (count < DEPTH_C) && !redirect_valid && !trapHold;
   assign imem_req_addr  = fetchPc;
   assign reqFire        = imem_req_valid && imem_req_ready;

   // Responses arriving in a redirect cycle are accounted for in the new drop count instead.
   assign rspFill = !rst && imem_rsp_valid && (dropCnt == '0) && !redirect_valid;
   assign rspDrop = imem_rsp_valid && (dropCnt != '0);

   assign instr_valid    = !rst && (count != '0) && filledMem[headPtr];
   assign pop            = instr_valid && instr_ready;
   assign instr          = rst ? 32'h0 : instrMem[headPtr];
   assign instr_pc       = rst ? '0 : pcMem[headPtr];
   assign instr_pc_plus4 = rst ? '0 : pcMem[headPtr] + XLEN'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPc     <= RESET_PC;
         allocPtr    <= '0;
         fillPtr     <= '0;
         headPtr     <= '0;
         count       <= '0;
         dropCnt     <= '0;
         unfilledCnt <= '0;
      end else if (redirect_valid) begin
         fetchPc     <= redirTarget;
         allocPtr    <= '0;
         fillPtr     <= '0;
         headPtr     <= '0;
         count       <= '0;
         unfilledCnt <= '0;
         // Outstanding IMEM traffic is assumed bounded so this stays within DEPTH.
         dropCnt     <= dropCnt + unfilledCnt - CNTW'(imem_rsp_valid);
      end else begin
         if (reqFire) begin
            allocPtr <= allocPtr + PTRW'(1);
            fetchPc  <= fetchPc + XLEN'(4);
         end
         if (rspFill) begin
            fillPtr <= fillPtr + PTRW'(1);
         end
         if (rspDrop) begin
            dropCnt <= dropCnt - CNTW'(1);
         end
         if (pop) begin
            headPtr <= headPtr + PTRW'(1);
         end
         count       <= count + CNTW'(reqFire) - CNTW'(pop);
         unfilledCnt <= unfilledCnt + CNTW'(reqFire) - CNTW'(rspFill);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : gEntry
         logic [XLEN-1:0] pcR;
         logic [31:0]     instrR;
         logic            filledR;

         always_ff @(posedge clk) begin
            if (rst) begin
               pcR     <= '0;
               instrR  <= '0;
               filledR <= 1'b0;
            end else if (redirect_valid) begin
               filledR <= 1'b0;
            end else begin
               if (reqFire && (allocPtr == PTRW'(gi))) begin
                  pcR     <= fetchPc;
                  filledR <= 1'b0;
               end
               if (rspFill && (fillPtr == PTRW'(gi))) begin
                  instrR  <= imem_rsp_data;
                  filledR <= 1'b1;
               end
            end
         end

         assign pcMem[gi]     = pcR;
         assign instrMem[gi]  = instrR;
         assign filledMem[gi] = filledR;
      end
   endgenerate

endmodule

// File: tb/tb_fetch_stage_q.sv
// Directed bench for fetch_stage_q with a fixed-latency IMEM model (latency 1 or 2 cycles).
module tb_fetch_stage_q;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   int total = 0;
   int bad   = 0;
   int memLat = 1;
   int fireCnt;
   logic saw200;
   logic [2:0]  pipeV;
   logic [31:0] pipeA [3];

   always #5 clk = ~clk;

   fetch_stage_q #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .rst(rst),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_pc_plus4(instr_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign(fetch_misalign)
`endif
   );

   // IMEM: in-order shift pipeline; instruction word is 0xC0DE0000 | addr[15:0].
   always @(posedge clk) begin
      if (rst) begin
         pipeV   <= '0;
         fireCnt <= 0;
         saw200  <= 1'b0;
      end else begin
         pipeV    <= {pipeV[1:0], imem_req_valid && imem_req_ready};
         pipeA[2] <= pipeA[1];
         pipeA[1] <= pipeA[0];
         pipeA[0] <= imem_req_addr;
         if (imem_req_valid && imem_req_ready) begin
            fireCnt <= fireCnt + 1;
            if (imem_req_addr == 32'h200) saw200 <= 1'b1;
         end
      end
   end

   assign imem_rsp_valid = pipeV[memLat-1];
   assign imem_rsp_data  = 32'hC0DE_0000 | {16'h0, pipeA[memLat-1][15:0]};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         $display("[%0t] %s obs=%0h exp=%0h ok", $time, tag, obs, exp);
      end else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic nextc;
      @(negedge clk);
      #1;
   endtask

   task automatic doReset(input int lat);
      rst = 1'b1;
      redirect_valid = 1'b0;
      #1;
      chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
      chk("rst_instr_valid", 64'(instr_valid), 64'h0);
      chk("rst_instr", 64'(instr), 64'h0);
      chk("rst_pc", 64'(instr_pc), 64'h0);
      chk("rst_pc4", 64'(instr_pc_plus4), 64'h0);
      memLat = lat;
      repeat (2) nextc;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;

      // Power-on reset for three cycles, then streaming at 1-cycle latency
      repeat (3) nextc;
      chk("por_req_valid", 64'(imem_req_valid), 64'h0);
      chk("por_instr_valid", 64'(instr_valid), 64'h0);
      chk("por_pc4", 64'(instr_pc_plus4), 64'h0);
      rst = 1'b0;
      #1;
      chk("s1_c0_req_valid", 64'(imem_req_valid), 64'h1);
      chk("s1_c0_addr", 64'(imem_req_addr), 64'h0);
      nextc;
      chk("s1_c1_instr_valid", 64'(instr_valid), 64'h0);
      chk("s1_c1_addr", 64'(imem_req_addr), 64'h4);
      nextc;
      chk("s1_c2_instr_valid", 64'(instr_valid), 64'h1);
      chk("s1_c2_pc", 64'(instr_pc), 64'h0);
      chk("s1_c2_pc4", 64'(instr_pc_plus4), 64'h4);
      chk("s1_c2_instr", 64'(instr), 64'hC0DE_0000);
      nextc;
      chk("s1_c3_pc", 64'(instr_pc), 64'h4);
      chk("s1_c3_instr", 64'(instr), 64'hC0DE_0004);
      nextc;
      chk("s1_c4_valid", 64'(instr_valid), 64'h1);
      chk("s1_c4_pc", 64'(instr_pc), 64'h8);

      // Decode stalled: buffer fills to DEPTH, then one pop reopens fetch
      doReset(1);
      instr_ready = 1'b0;
      repeat (3) nextc;
      chk("s2_c3_req_valid", 64'(imem_req_valid), 64'h1);
      chk("s2_c3_addr", 64'(imem_req_addr), 64'hC);
      nextc;
      chk("s2_c4_req_valid", 64'(imem_req_valid), 64'h0);
      chk("s2_c4_pc", 64'(instr_pc), 64'h0);
      repeat (2) nextc;
      chk("s2_fire_cnt", 64'(fireCnt), 64'd4);
      chk("s2_c6_req_valid", 64'(imem_req_valid), 64'h0);
      instr_ready = 1'b1;
      nextc;
      chk("s2_c7_req_valid", 64'(imem_req_valid), 64'h1);
      chk("s2_c7_addr", 64'(imem_req_addr), 64'h10);
      chk("s2_c7_pc", 64'(instr_pc), 64'h4);

      // 2-cycle IMEM, redirect with two requests outstanding
      doReset(2);
      repeat (2) nextc;
      chk("s3_c2_rsp", 64'(imem_rsp_valid), 64'h1);
      chk("s3_c2_instr_valid", 64'(instr_valid), 64'h0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chk("s3_c2_req_blocked", 64'(imem_req_valid), 64'h0);
      nextc;
      redirect_valid = 1'b0;
      #1;
      chk("s3_c3_addr", 64'(imem_req_addr), 64'h100);
      chk("s3_c3_req_valid", 64'(imem_req_valid), 64'h1);
      nextc;
      chk("s3_c4_instr_valid", 64'(instr_valid), 64'h0);
      nextc;
      chk("s3_c5_instr_valid", 64'(instr_valid), 64'h0);
      nextc;
      chk("s3_c6_instr_valid", 64'(instr_valid), 64'h1);
      chk("s3_c6_pc", 64'(instr_pc), 64'h100);
      chk("s3_c6_instr", 64'(instr), 64'hC0DE_0100);

      // Redirect coinciding with a response and a decode pop
      doReset(2);
      repeat (3) nextc;
      chk("s4_c3_pc", 64'(instr_pc), 64'h0);
      nextc;
      chk("s4_c4_valid", 64'(instr_valid), 64'h1);
      chk("s4_c4_pc", 64'(instr_pc), 64'h4);
      chk("s4_c4_rsp", 64'(imem_rsp_valid), 64'h1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h400;
      nextc;
      redirect_valid = 1'b0;
      #1;
      chk("s4_c5_drop_cnt", 64'(dut.dropCnt), 64'd1);
      chk("s4_c5_addr", 64'(imem_req_addr), 64'h400);
      chk("s4_c5_instr_valid", 64'(instr_valid), 64'h0);
      nextc;
      chk("s4_c6_instr_valid", 64'(instr_valid), 64'h0);
      nextc;
      chk("s4_c7_instr_valid", 64'(instr_valid), 64'h0);
      nextc;
      chk("s4_c8_pc", 64'(instr_pc), 64'h400);
      chk("s4_c8_instr", 64'(instr), 64'hC0DE_0400);

      // Back-to-back redirects: last target wins
      doReset(1);
      nextc;
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      nextc;
      redirect_pc = 32'h300;
      #1;
      chk("s5_c2_req_valid", 64'(imem_req_valid), 64'h0);
      nextc;
      redirect_valid = 1'b0;
      #1;
      chk("s5_c3_addr", 64'(imem_req_addr), 64'h300);
      nextc;
      chk("s5_c4_instr_valid", 64'(instr_valid), 64'h0);
      nextc;
      chk("s5_c5_pc", 64'(instr_pc), 64'h300);
      chk("s5_c5_instr", 64'(instr), 64'hC0DE_0300);
      chk("s5_no_200", 64'(saw200), 64'h0);

      // PC wrap at the top of the address space
      doReset(1);
      nextc;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      nextc;
      redirect_valid = 1'b0;
      #1;
      chk("s6_c2_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
      nextc;
      chk("s6_c3_addr_wrap", 64'(imem_req_addr), 64'h0);
      nextc;
      chk("s6_c4_pc", 64'(instr_pc), 64'hFFFF_FFFC);
      chk("s6_c4_pc4", 64'(instr_pc_plus4), 64'h0);
      chk("s6_c4_instr", 64'(instr), 64'hC0DE_FFFC);

      // Misaligned redirect target
      doReset(1);
      nextc;
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      nextc;
      redirect_valid = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("s7_c2_misalign", 64'(fetch_misalign), 64'h1);
      chk("s7_c2_req_valid", 64'(imem_req_valid), 64'h0);
      nextc;
      chk("s7_c3_misalign", 64'(fetch_misalign), 64'h1);
      chk("s7_c3_req_valid", 64'(imem_req_valid), 64'h0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h104;
      nextc;
      redirect_valid = 1'b0;
      #1;
      chk("s7_c4_misalign", 64'(fetch_misalign), 64'h0);
      chk("s7_c4_addr", 64'(imem_req_addr), 64'h104);
      chk("s7_c4_req_valid", 64'(imem_req_valid), 64'h1);
      repeat (2) nextc;
      chk("s7_c6_pc", 64'(instr_pc), 64'h104);
`else
      chk("s7_c2_addr_aligned", 64'(imem_req_addr), 64'h100);
      chk("s7_c2_req_valid", 64'(imem_req_valid), 64'h1);
      repeat (2) nextc;
      chk("s7_c4_pc", 64'(instr_pc), 64'h100);
      chk("s7_c4_instr", 64'(instr), 64'hC0DE_0100);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage_q.md
Name: fetch_stage_q

Overview:
Parametrised instruction-fetch stage with a decoupled instruction-memory interface and an in-order prefetch buffer.
- Generates the PC and issues requests to a variable-latency IMEM.
- Buffers up to DEPTH fetched instructions and presents them to decode over a valid/ready handshake.
- Handles branch, JAL and JALR redirects from execute by flushing the buffer and discarding in-flight wrong-path responses.
- Sits between the PC/redirect logic and the F/D boundary.

Parameters:
XLEN, 32, address/instruction width (instruction field is always 32 bits; XLEN sizes the PC).
DEPTH, 4, prefetch buffer entries; power of two, >=2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
redirect_valid  input  1  execute redirect (branch taken, JAL or JALR), single-cycle pulse
redirect_pc  input  XLEN  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  IMEM accepts request
imem_req_addr  output  XLEN  fetch address
imem_rsp_valid  input  1  response valid; responses return in request order, no backpressure
imem_rsp_data  input  32  fetched instruction
instr_valid  output  1  head entry valid to decode
instr_ready  input  1  decode accepts
instr  output  32  instruction
instr_pc  output  XLEN  PC of instr
instr_pc_plus4  output  XLEN  instr_pc+4, modulo 2^XLEN

Behaviour:
Entry format and pointers:
- Each entry holds {pc, instr, filled}.
- alloc_ptr, fill_ptr and head_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH.
- count is the number of allocated entries, 0..DEPTH.

Request issue:
- imem_req_valid = !rst && count<DEPTH && !redirect_valid.
- imem_req_addr = fetch_pc.
- Request fires on valid&&ready. On fire: allocate the entry at alloc_ptr with pc=fetch_pc and filled=0, then fetch_pc <= fetch_pc+4 (wraps).
- imem_req_valid may deassert without a handshake; IMEM must not rely on valid stability.

Response:
- If drop_cnt>0: discard the response and decrement drop_cnt.
- Otherwise: write instr at fill_ptr, set filled, advance fill_ptr.

Decode handshake:
- instr_valid = count>0 && head filled.
- Outputs are driven directly from the head entry.
- valid&&ready pops the head. Data from the buffer reaches decode no earlier than 1 cycle after the response (registered).

Latency and throughput:
- Minimum IMEM response to instr_valid is 1 cycle.
- Sustained 1 instr/cycle with an always-ready, fixed-latency IMEM once latency <= DEPTH-1.

Full/empty:
- count==DEPTH blocks requests.
- Simultaneous pop and allocate keeps count unchanged.
- A pop is allowed when count==DEPTH.

Redirect (cycle T, redirect_valid=1):
- No request is issued in T.
- At the T edge: fetch_pc <= redirect_pc, all entries are invalidated, and pointers and count are cleared.
- drop_cnt <= (allocated-unfilled entries) + drop_cnt - (1 if a response arrives in T).
- A decode pop in T still completes; the popped instruction is wrong-path and squashed downstream.
- The first request for redirect_pc issues in T+1.

drop_cnt width and invariant: log2(DEPTH)+1 bits; never exceeds DEPTH.

Back-to-back redirects: each redirect recomputes drop_cnt; the last one wins fetch_pc.

Reset (synchronous, active-high):
- fetch_pc=RESET_PC, count=0, all pointers 0, drop_cnt=0, all filled=0.
- While rst is high: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, instr_pc_plus4=0.
- Responses arriving during rst are ignored.
- Reset mid-operation loses outstanding requests; the IMEM is assumed reset together with this block.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Enabled:
  - Extra output fetch_misalign (1 bit, registered, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign at the next edge and holds it.
  - While it is set, requests are suppressed; it clears only on a subsequent aligned redirect or on rst.
- Disabled: the port is absent and redirect_pc[1:0] is forced to 0 before use.

Test Plan:
- rst high 3 cycles then low, IMEM always ready, 1-cycle latency -> first request addr 0x0 in the first cycle after reset; instr_valid with instr_pc=0x0, instr_pc_plus4=0x4 two cycles later; then one instr/cycle at 0x4, 0x8, ...
- Hold instr_ready=0 with DEPTH=4 -> exactly 4 requests (0x0..0xC), then imem_req_valid=0. Raise instr_ready -> requests resume at 0x10 in the same cycle a pop frees an entry.
- 2-cycle IMEM latency, redirect_valid with redirect_pc=0x100 while 2 requests are outstanding -> both responses dropped, next request addr 0x100, first delivered instr_pc=0x100.
- Redirect in the same cycle as an in-flight response and a decode pop -> pop completes, response dropped, drop_cnt equals remaining outstanding requests, no stale instr delivered.
- Two consecutive redirects, 0x200 then 0x300 -> no request to 0x200 is delivered, first instr_pc=0x300.
- FETCH_MISALIGN_TRAP_EN defined, redirect_pc=0x102 -> fetch_misalign=1 next cycle and imem_req_valid=0. Redirect to 0x104 -> fetch_misalign=0 and fetch resumes at 0x104.
